// File: rtl/heichips25_mux_pkg.sv
// Shared types and default parameters for the multi-design project multiplexer.
package heichips25_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT      = 2'd1,
    ST_RESET_HOLD = 2'd2,
    ST_RUN        = 2'd3
  } mux_state_e;

  localparam int unsigned DEF_N_PROJ      = 4;
  localparam int unsigned DEF_W           = 8;
  localparam int unsigned DEF_RST_CYCLES  = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/heichips25_sync.sv
// Multi-flop synchroniser for an asynchronous pad input into the clk domain.
module heichips25_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/heichips25_project_mux.sv
// Selects one of N_PROJ user designs via a serial cfg word, sequences its
// enable/reset, and routes the shared pad buses only to that design.
module heichips25_project_mux
  import heichips25_mux_pkg::*;
#(
  parameter  int unsigned N_PROJ      = DEF_N_PROJ,
  parameter  int unsigned W           = DEF_W,
  parameter  int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter  int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int unsigned SEL_W       = $clog2(N_PROJ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_en,
  input  logic                cfg_data,
  input  logic [W-1:0]        ui_in,
  output logic [W-1:0]        uo_out,
  input  logic [W-1:0]        uio_in,
  output logic [W-1:0]        uio_out,
  output logic [W-1:0]        uio_oe,
  output logic [N_PROJ*W-1:0] proj_ui,
  output logic [N_PROJ*W-1:0] proj_uio_in,
  input  logic [N_PROJ*W-1:0] proj_uo,
  input  logic [N_PROJ*W-1:0] proj_uio_out,
  input  logic [N_PROJ*W-1:0] proj_uio_oe,
  output logic [N_PROJ-1:0]   proj_ena,
  output logic [N_PROJ-1:0]   proj_rst_n,
  output logic [SEL_W-1:0]    active_sel,
  output logic                busy
);

  localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  mux_state_e        r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_shreg, w_shreg_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [N_PROJ-1:0] r_proj_ena, r_proj_rst_n;
  logic              r_busy;
  logic              w_en_s, w_data_s, w_run;

  heichips25_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .i_clk(clk), .i_rst(rst), .i_d(cfg_en), .o_q(w_en_s)
  );

  heichips25_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .i_clk(clk), .i_rst(rst), .i_d(cfg_data), .o_q(w_data_s)
  );

  // A cfg window pre-empts every state so the old design drops out immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    if (w_en_s) begin
      w_state_nxt = ST_SHIFT;
      w_shreg_nxt = (r_state == ST_SHIFT) ? SEL_W'({r_shreg, w_data_s})
                                          : SEL_W'(w_data_s);
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (32'(r_shreg) < N_PROJ) begin
            w_sel_nxt   = r_shreg;
            w_cnt_nxt   = CNT_W'(RST_CYCLES - 1);
            w_state_nxt = ST_RESET_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RESET_HOLD: begin
          if (r_cnt == '0) w_state_nxt = ST_RUN;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Enables and resets are registered from the next state so they track it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_sel        <= '0;
      r_cnt        <= '0;
      r_proj_ena   <= '0;
      r_proj_rst_n <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_sel        <= w_sel_nxt;
      r_cnt        <= w_cnt_nxt;
      r_proj_ena   <= (w_state_nxt == ST_RESET_HOLD || w_state_nxt == ST_RUN)
                      ? (N_PROJ'(1) << w_sel_nxt) : '0;
      r_proj_rst_n <= (w_state_nxt == ST_RUN) ? (N_PROJ'(1) << w_sel_nxt) : '0;
      r_busy       <= (w_state_nxt == ST_SHIFT || w_state_nxt == ST_RESET_HOLD);
    end
  end

  assign w_run = (r_state == ST_RUN);

  // Pad data path stays combinational; only the selected slice is ever non-zero.
  always_comb begin
    uo_out      = '0;
    uio_out     = '0;
    uio_oe      = '0;
    proj_ui     = '0;
    proj_uio_in = '0;
    if (w_run) begin
      uo_out                    = proj_uo[r_sel*W +: W];
      uio_out                   = proj_uio_out[r_sel*W +: W];
      uio_oe                    = proj_uio_oe[r_sel*W +: W];
      proj_ui[r_sel*W +: W]     = ui_in;
      proj_uio_in[r_sel*W +: W] = uio_in;
    end
  end

  assign proj_ena   = r_proj_ena;
  assign proj_rst_n = r_proj_rst_n;
  assign active_sel = r_sel;
  assign busy       = r_busy;

endmodule

// File: tb/tb_heichips25_project_mux.sv
// Directed bench for heichips25_project_mux (N_PROJ=3) with a per-cycle
// behavioural model of the selection protocol and hand-computed spot checks.
module tb_heichips25_project_mux;

  localparam int N     = 3;
  localparam int W     = 8;
  localparam int RC    = 16;
  localparam int SS    = 2;
  localparam int SEL_W = 2;

  logic           clk = 1'b0;
  logic           rst, cfg_en, cfg_data;
  logic [W-1:0]   ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic [N*W-1:0] proj_ui, proj_uio_in, proj_uo, proj_uio_out, proj_uio_oe;
  logic [N-1:0]   proj_ena, proj_rst_n;
  logic [SEL_W-1:0] active_sel;
  logic           busy;

  logic [N*W-1:0] uo_v  = 24'h3C2211;
  logic [N*W-1:0] uout_v = 24'hC34433;
  logic [N*W-1:0] uoe_v = 24'hF00FAA;

  assign proj_uo      = uo_v;
  assign proj_uio_out = uout_v;
  assign proj_uio_oe  = uoe_v;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  heichips25_project_mux #(.N_PROJ(N), .W(W), .RST_CYCLES(RC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_data(cfg_data),
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe),
    .proj_ui(proj_ui), .proj_uio_in(proj_uio_in), .proj_uo(proj_uo),
    .proj_uio_out(proj_uio_out), .proj_uio_oe(proj_uio_oe),
    .proj_ena(proj_ena), .proj_rst_n(proj_rst_n), .active_sel(active_sel), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 receiving word, 2 held in reset, 3 live.
  int m_mode, m_word, m_sel, m_held;
  bit pe[SS];
  bit pd[SS];
  bit es, ds;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_word = 0; m_sel = 0; m_held = 0;
      for (int i = 0; i < SS; i++) begin pe[i] = 1'b0; pd[i] = 1'b0; end
    end else begin
      es = pe[SS-1];
      ds = pd[SS-1];
      if (es) begin
        m_word = (m_mode == 1) ? (m_word * 2 + int'(ds)) % (1 << SEL_W) : int'(ds);
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_word < N) begin m_sel = m_word; m_held = 0; m_mode = 2; end
        else m_mode = 0;
      end else if (m_mode == 2) begin
        m_held++;
        if (m_held == RC) m_mode = 3;
      end
      for (int i = SS-1; i > 0; i--) begin pe[i] = pe[i-1]; pd[i] = pd[i-1]; end
      pe[0] = cfg_en;
      pd[0] = cfg_data;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  logic [N-1:0]   e_ena, e_rstn;
  logic [N*W-1:0] e_ui, e_uioin;
  bit e_live, e_run;
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      e_live = (m_mode == 2 || m_mode == 3);
      e_run  = (m_mode == 3);
      e_ena  = e_live ? N'(1 << m_sel) : '0;
      e_rstn = e_run  ? N'(1 << m_sel) : '0;
      e_ui = '0; e_uioin = '0;
      if (e_run) begin
        e_ui[m_sel*W +: W]    = ui_in;
        e_uioin[m_sel*W +: W] = uio_in;
      end
      check("m_ena", proj_ena, e_ena);
      check("m_rst_n", proj_rst_n, e_rstn);
      check("m_busy", busy, (m_mode == 1 || m_mode == 2));
      check("m_sel", active_sel, m_sel);
      check("m_uo", uo_out, e_run ? uo_v[m_sel*W +: W] : 8'h00);
      check("m_uio_out", uio_out, e_run ? uout_v[m_sel*W +: W] : 8'h00);
      check("m_uio_oe", uio_oe, e_run ? uoe_v[m_sel*W +: W] : 8'h00);
      check("m_proj_ui", proj_ui, e_ui);
      check("m_proj_uio_in", proj_uio_in, e_uioin);
      check("ena_onehot", ($countones(proj_ena) <= 1), 1);
    end
  end

  task automatic send_word(input logic [7:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      @(negedge clk); cfg_en = 1'b1; cfg_data = bits[i];
    end
    @(negedge clk); cfg_en = 1'b0; cfg_data = 1'b0;
  endtask

  task automatic wait_ena(input int p, input int budget);
    int n;
    n = 0;
    while (proj_ena[p] !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
    if (proj_ena[p] !== 1'b1) begin
      n_checks++; n_err++;
      $display("FAIL wait_ena%0d: timeout after %0d cycles", p, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] vals [4];
    vals[0] = 8'h01; vals[1] = 8'hFF; vals[2] = 8'h80; vals[3] = 8'h5A;
    rst = 1'b1; cfg_en = 1'b0; cfg_data = 1'b0; ui_in = 8'hA5; uio_in = 8'h5A;
    @(posedge clk); chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ena", proj_ena, 3'b000);
    check("rst_rst_n", proj_rst_n, 3'b000);
    check("rst_busy", busy, 0);
    check("rst_uio_oe", uio_oe, 8'h00);
    @(negedge clk); rst = 1'b0;

    // Select design 2, measure the reset hold, then check the data path.
    send_word(8'b10, 2);
    wait_ena(2, 20);
    check("sel2_ena", proj_ena, 3'b100);
    check("sel2_busy", busy, 1);
    n = 0;
    while (proj_ena[2] === 1'b1 && proj_rst_n[2] === 1'b0 && n < 100) begin
      n++; @(posedge clk); #1;
    end
    check("hold_len", n, 16);
    check("run2_rst_n", proj_rst_n, 3'b100);
    check("run2_uo", uo_out, 8'h3C);
    check("run2_ui", proj_ui, 24'hA50000);
    check("run2_uioin", proj_uio_in, 24'h5A0000);
    check("run2_oe", uio_oe, 8'hF0);
    check("run2_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); ui_in = vals[i]; #1;
      check("run2_ui_vec", proj_ui, {vals[i], 16'h0000});
    end

    // Switch to design 1.
    send_word(8'b01, 2);
    wait_ena(1, 20);
    check("sel1_ena", proj_ena, 3'b010);
    repeat (16) @(posedge clk);
    #1;
    check("run1_uo", uo_out, 8'h22);
    check("run1_rst_n", proj_rst_n, 3'b010);

    // Invalid word for N_PROJ=3.
    send_word(8'b11, 2);
    repeat (6) @(posedge clk);
    #1;
    check("inv_ena", proj_ena, 3'b000);
    check("inv_oe", uio_oe, 8'h00);
    check("inv_busy", busy, 0);
    check("inv_sel", active_sel, 2'd1);

    // Overlong word keeps only the last two bits.
    send_word(8'b0110, 4);
    wait_ena(2, 20);
    check("long_sel", active_sel, 2'd2);

    // One-cycle window: the single bit is the word.
    send_word(8'b1, 1);
    wait_ena(1, 20);
    check("one_sel", active_sel, 2'd1);

    // Reset in the middle of the hold (counter at 5).
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ena", proj_ena, 3'b000);
    check("mid_rst_sel", active_sel, 2'd0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;

    // Selection after reset works normally.
    send_word(8'b00, 2);
    wait_ena(0, 20);
    repeat (16) @(posedge clk);
    #1;
    check("run0_uo", uo_out, 8'h11);
    check("run0_rst_n", proj_rst_n, 3'b001);

    repeat (4) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
